// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seqdet_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ARMED,
        ST_MATCH
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0011;

    function automatic int tick_cnt_w(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/seqdet_tick_gen.sv
// Modulo-TICK_DIV sample tick; tick is 1 while the counter sits at 0.
module seqdet_tick_gen
    import seqdet_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk_in,
    input  logic reset,
    output logic tick
);

    localparam int W = tick_cnt_w(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial pattern detector with run-time pattern reload.
// Match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int             PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter bit             OVERLAP  = 1'b1,
    parameter int             TICK_DIV = 1,
    parameter int             CNT_W    = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             dout,
    output logic [CNT_W-1:0] match_count,
    output logic             tick_out
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic             tick;
    state_t           state, state_n;
    logic [PAT_W-1:0] hist, hist_n, pat, pat_n, shifted;
    logic [FW-1:0]    fill, fill_n, fill_inc;

    seqdet_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_in(clk_in),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= ST_FILL;
            hist  <= '0;
            fill  <= '0;
            pat   <= PATTERN;
        end else begin
            state <= state_n;
            hist  <= hist_n;
            fill  <= fill_n;
            pat   <= pat_n;
        end
    end

    always_comb begin
        state_n  = state;
        hist_n   = hist;
        fill_n   = fill;
        pat_n    = pat;
        shifted  = (hist << 1) | PAT_W'(din);
        fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
        unique case (1'b1)
            pat_load: begin
                pat_n   = pat_in;
                hist_n  = '0;
                fill_n  = '0;
                state_n = ST_FILL;
            end
            tick && !pat_load: begin
                hist_n = shifted;
                fill_n = fill_inc;
                if (fill_inc == FULL && shifted == pat) begin
                    state_n = ST_MATCH;
                    // non-overlapping: the matched bits may not be reused
                    if (!OVERLAP) fill_n = '0;
                end else begin
                    state_n = (fill_inc == FULL) ? ST_ARMED : ST_FILL;
                end
            end
            default: ;
        endcase
    end

    assign dout     = (state == ST_MATCH);
    assign tick_out = tick;

`ifdef SEQDET_COUNT_EN
    logic             hit;
    logic [CNT_W-1:0] cnt;

    // state_n only becomes MATCH via a fresh compare on an unloaded tick
    assign hit = tick && !pat_load && (state_n == ST_MATCH);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (hit && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed check of seq_detect_param against a bit-history model.
module tb_seq_detect_param;

`ifdef SEQDET_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       pat_load;
    logic [3:0] pat_in;

    logic       dout0, dout1, dout2;
    logic       tk0, tk1, tk2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_detect_param u0 (
        .clk_in(clk), .reset(rst_n), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .dout(dout0), .match_count(cnt0), .tick_out(tk0)
    );

    seq_detect_param #(.OVERLAP(1'b0)) u1 (
        .clk_in(clk), .reset(rst_n), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .dout(dout1), .match_count(cnt1), .tick_out(tk1)
    );

    seq_detect_param #(.TICK_DIV(4), .CNT_W(2)) u2 (
        .clk_in(clk), .reset(rst_n), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .dout(dout2), .match_count(cnt2), .tick_out(tk2)
    );

    // model: keep the last valid samples as an integer plus a valid count
    int   DIVS[3] = '{1, 1, 4};
    bit   OVL [3] = '{1'b1, 1'b0, 1'b1};
    int   CMAX[3] = '{255, 255, 3};
    int   hv[3], nv[3], cyc[3], mc[3];
    int   mp[3];
    bit   md[3];

    always @(posedge clk or negedge rst_n) begin
        bit t;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                hv[k] = 0; nv[k] = 0; cyc[k] = 0;
                mc[k] = 0; mp[k] = 3; md[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                t = (cyc[k] % DIVS[k]) == 0;
                cyc[k]++;
                if (pat_load) begin
                    mp[k] = int'(pat_in);
                    hv[k] = 0; nv[k] = 0; md[k] = 1'b0;
                end else if (t) begin
                    hv[k] = ((hv[k] * 2) + int'(din)) % 16;
                    if (nv[k] < 4) nv[k]++;
                    md[k] = (nv[k] == 4) && (hv[k] == mp[k]);
                    if (md[k]) begin
                        if (mc[k] < CMAX[k]) mc[k]++;
                        if (!OVL[k]) nv[k] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ecnt(input int n);
        return CE ? n : 0;
    endfunction

    always @(negedge clk) begin
        chk("dout0", int'(dout0), int'(md[0]));
        chk("dout1", int'(dout1), int'(md[1]));
        chk("dout2", int'(dout2), int'(md[2]));
        chk("cnt0", int'(cnt0), ecnt(mc[0]));
        chk("cnt1", int'(cnt1), ecnt(mc[1]));
        chk("cnt2", int'(cnt2), ecnt(mc[2]));
        chk("tick0", int'(tk0), int'((cyc[0] % 1) == 0));
        chk("tick2", int'(tk2), int'((cyc[2] % 4) == 0));
    end

    task automatic drv(input bit d, input bit pl, input logic [3:0] pi);
        din = d; pat_load = pl; pat_in = pi;
        @(negedge clk); #1;
    endtask

    task automatic smp(input bit d);
        drv(d, 1'b0, 4'b0000);
    endtask

    task automatic do_reset();
        din = 1'b0; pat_load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt2", int'(cnt2), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit [3:0] s;
        int r;
        rst_n = 1'b0; din = 1'b0; pat_load = 1'b0; pat_in = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        chk("init_dout", int'(dout0), 0);
        chk("init_cnt", int'(cnt0), 0);
        chk("init_tick", int'(tk0), 1);
        rst_n = 1'b1;

        smp(0); smp(0); smp(1); smp(1);
        chk("p0011_dout", int'(dout0), 1);
        chk("p0011_cnt", int'(cnt0), ecnt(1));
        smp(0);
        chk("p0011_pulse_end", int'(dout0), 0);
        smp(0); smp(1); smp(1);
        chk("p0011_second", int'(dout0), 1);
        chk("p0011_cnt2", int'(cnt0), ecnt(2));

        do_reset();
        drv(0, 1'b1, 4'b0101);
        smp(0); smp(1); smp(0); smp(1);
        chk("p0101_ov_s4", int'(dout0), 1);
        chk("p0101_nov_s4", int'(dout1), 1);
        smp(0); smp(1);
        chk("p0101_ov_s6", int'(dout0), 1);
        chk("p0101_nov_s6", int'(dout1), 0);
        chk("p0101_ov_cnt", int'(cnt0), ecnt(2));
        chk("p0101_nov_cnt", int'(cnt1), ecnt(1));

        do_reset();
        smp(0); smp(0); smp(1);
        do_reset();
        smp(1);
        chk("midrst_dout", int'(dout0), 0);

        drv(1, 1'b1, 4'b1010);
        smp(1); smp(0); smp(1);
        chk("load_s3", int'(dout0), 0);
        smp(0);
        chk("load_s4", int'(dout0), 1);

        do_reset();
        s = 4'b0011;
        for (int m = 0; m < 5; m++)
            for (int b = 3; b >= 0; b--)
                repeat (4) smp(s[b]);
        chk("sat_cnt2", int'(cnt2), ecnt(3));

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 299));
            if (r == 0) do_reset();
            else drv(1'($urandom), ($urandom_range(0, 39) == 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
